// File: rtl/avalon_sdram_responder_pkg.sv
// ---------------------------------------------------------------------------
// avalon_sdram_responder_pkg
//   Shared definitions for the avalon_sdram_* bus: default bus widths, the
//   byte-lane width derivation, the wait-counter width and the legal ranges
//   of the responder timing parameters (also used by the controller wrapper
//   and by the bench).
// ---------------------------------------------------------------------------
package avalon_sdram_responder_pkg;

  // Default bus widths, matching the SDRAM controller.
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  // Wait-state counter width; bounds WAIT_CYCLES to 0..15.
  localparam int WCNT_W = 4;

  // Legal timing parameter ranges.
  localparam int WAIT_CYCLES_MIN  = 0;
  localparam int WAIT_CYCLES_MAX  = 15;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 8;

  // Number of byte lanes on a data bus of the given width.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// ---------------------------------------------------------------------------
// avalon_rd_pipe
//   LATENCY-deep shift register of {valid, data} carrying read returns from
//   the RAM to the bus. Synchronous clear drops every in-flight entry.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high clear
//   i_valid  in   read accepted this cycle
//   i_data   in   RAM data for that read
//   o_valid  out  registered readdatavalid
//   o_data   out  registered readdata (zero when o_valid is low)
// ---------------------------------------------------------------------------
module avalon_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [DATA_W-1:0]  r_data [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      // Empty slots carry zero so readdata is quiet between returns.
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/avalon_sdram_responder.sv
// ---------------------------------------------------------------------------
// avalon_sdram_responder
//   Avalon-MM slave standing in for the SDRAM controller: block-RAM backed,
//   WAIT_CYCLES wait-states after each accepted command, fixed READ_LATENCY
//   read returns, and a sticky flag for illegal read+write commands.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   avalon_sdram_address          word address (aliases modulo 2^MEM_AW)
//   avalon_sdram_byteenable_n     active-low write byte lanes
//   avalon_sdram_chipselect       command qualifier
//   avalon_sdram_writedata        write data
//   avalon_sdram_read_n/write_n   active-low read / write requests
//   avalon_sdram_readdata         read data, valid with readdatavalid
//   avalon_sdram_readdatavalid    one pulse per accepted read
//   avalon_sdram_waitrequest      registered stall
//   proto_err                     sticky illegal-command flag
// ---------------------------------------------------------------------------
module avalon_sdram_responder
  import avalon_sdram_responder_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_AW       = 10,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   avalon_sdram_address,
  input  logic [DATA_W/8-1:0] avalon_sdram_byteenable_n,
  input  logic                avalon_sdram_chipselect,
  input  logic [DATA_W-1:0]   avalon_sdram_writedata,
  input  logic                avalon_sdram_read_n,
  input  logic                avalon_sdram_write_n,
  output logic [DATA_W-1:0]   avalon_sdram_readdata,
  output logic                avalon_sdram_readdatavalid,
  output logic                avalon_sdram_waitrequest,
  output logic                proto_err
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int DEPTH = 2 ** MEM_AW;

  logic [MEM_AW-1:0] w_idx;
  logic              w_req;
  logic              w_illegal;
  logic              w_accept;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_rd_data;
  logic [WCNT_W-1:0] w_wcnt_next;

  logic [WCNT_W-1:0] r_wcnt;
  logic              r_waitrequest;
  logic              r_proto_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Upper address bits are deliberately ignored: addresses wrap.
  assign w_idx = avalon_sdram_address[MEM_AW-1:0];

  if (ADDR_W > MEM_AW) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^avalon_sdram_address[ADDR_W-1:MEM_AW];
  end

  // Accept decode. Acceptance keys off the registered stall, so a command
  // held during waitrequest is taken on the first edge it drops.
  assign w_req     = avalon_sdram_chipselect &
                     (avalon_sdram_read_n ^ avalon_sdram_write_n);
  assign w_illegal = avalon_sdram_chipselect &
                     ~avalon_sdram_read_n & ~avalon_sdram_write_n;
  assign w_accept  = w_req & ~r_waitrequest;
  assign w_rd_acc  = w_accept & ~avalon_sdram_read_n;
  assign w_wr_acc  = w_accept & ~avalon_sdram_write_n;

  // Byte-lane RAM. Read is combinational into the first pipe stage, so a
  // read accepted at an edge sees every write accepted at earlier edges.
  // NOTE: the RAM has no reset; contents survive rst and it maps onto block
  // RAM, which cannot be cleared in one cycle anyway.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (!avalon_sdram_byteenable_n[i])
          r_mem[w_idx][8*i +: 8] <= avalon_sdram_writedata[8*i +: 8];
      end
    end
  end

  assign w_rd_data = r_mem[w_idx];

  // Wait-state counter: reload on accept, else count down to zero.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_wcnt_next = r_wcnt;
    if (w_accept)
      w_wcnt_next = WCNT_W'(WAIT_CYCLES);
    else if (r_wcnt != '0)
      w_wcnt_next = r_wcnt - WCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt        <= '0;
      r_waitrequest <= 1'b1;
      r_proto_err   <= 1'b0;
    end else begin
      r_wcnt        <= w_wcnt_next;
      r_waitrequest <= (w_wcnt_next != '0);
      if (w_illegal) r_proto_err <= 1'b1;
    end
  end

  avalon_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (DATA_W)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_acc),
    .i_data  (w_rd_data),
    .o_valid (avalon_sdram_readdatavalid),
    .o_data  (avalon_sdram_readdata)
  );

  assign avalon_sdram_waitrequest = r_waitrequest;
  assign proto_err                = r_proto_err;

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// ---------------------------------------------------------------------------
// tb_avalon_sdram_responder
//   Two responders: A (WAIT_CYCLES=1, READ_LATENCY=2) and B (WAIT_CYCLES=0,
//   READ_LATENCY=3). A behavioural model tracks, per responder, the earliest
//   edge a new command may be accepted, the memory image, and a map of
//   expected read returns keyed by return edge; the outputs are compared to
//   it on every falling edge. Directed tests add literal expectations.
// ---------------------------------------------------------------------------
module tb_avalon_sdram_responder;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int MEM_AW = 10;
  localparam int BE_W   = 2;
  localparam int DEPTH  = 1 << MEM_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst    [2];
  logic [ADDR_W-1:0] addr   [2];
  logic [BE_W-1:0]   be_n   [2];
  logic              cs     [2];
  logic [DATA_W-1:0] wdata  [2];
  logic              rd_n   [2];
  logic              wr_n   [2];
  logic [DATA_W-1:0] rdata  [2];
  logic              rdv    [2];
  logic              wreq   [2];
  logic              perr   [2];

  avalon_sdram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
    .WAIT_CYCLES(1), .READ_LATENCY(2)
  ) u_dut_a (
    .clk                        (clk),
    .rst                        (rst[0]),
    .avalon_sdram_address       (addr[0]),
    .avalon_sdram_byteenable_n  (be_n[0]),
    .avalon_sdram_chipselect    (cs[0]),
    .avalon_sdram_writedata     (wdata[0]),
    .avalon_sdram_read_n        (rd_n[0]),
    .avalon_sdram_write_n       (wr_n[0]),
    .avalon_sdram_readdata      (rdata[0]),
    .avalon_sdram_readdatavalid (rdv[0]),
    .avalon_sdram_waitrequest   (wreq[0]),
    .proto_err                  (perr[0])
  );

  avalon_sdram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
    .WAIT_CYCLES(0), .READ_LATENCY(3)
  ) u_dut_b (
    .clk                        (clk),
    .rst                        (rst[1]),
    .avalon_sdram_address       (addr[1]),
    .avalon_sdram_byteenable_n  (be_n[1]),
    .avalon_sdram_chipselect    (cs[1]),
    .avalon_sdram_writedata     (wdata[1]),
    .avalon_sdram_read_n        (rd_n[1]),
    .avalon_sdram_write_n       (wr_n[1]),
    .avalon_sdram_readdata      (rdata[1]),
    .avalon_sdram_readdatavalid (rdv[1]),
    .avalon_sdram_waitrequest   (wreq[1]),
    .proto_err                  (perr[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic string nm(input int d);
    return (d == 0) ? "A" : "B";
  endfunction

  function automatic int key(input int d, input int e);
    return d * (1 << 24) + e;
  endfunction

  // ---------------- behavioural model ----------------
  int                edge_n = 0;
  bit                started [2];
  int                next_ok [2];
  logic              perr_m  [2];
  logic              exp_wr  [2];
  logic              exp_v   [2];
  logic [DATA_W-1:0] exp_d   [2];
  logic [DATA_W-1:0] mem_m   [2][DEPTH];
  logic [DATA_W-1:0] ret_map [int];

  always @(posedge clk) begin
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      int idx;
      idx = int'(addr[d]) % DEPTH;
      if (rst[d]) begin
        started[d] = 1'b1;
        next_ok[d] = edge_n + 1;
        perr_m[d]  = 1'b0;
        for (int k = 0; k < 16; k++)
          if (ret_map.exists(key(d, edge_n + k))) ret_map.delete(key(d, edge_n + k));
      end else if (started[d]) begin
        if (cs[d] && !rd_n[d] && !wr_n[d]) begin
          perr_m[d] = 1'b1;
        end else if (cs[d] && (rd_n[d] != wr_n[d]) && edge_n >= next_ok[d]) begin
          next_ok[d] = edge_n + wait_of(d) + 1;
          if (!wr_n[d]) begin
            for (int i = 0; i < BE_W; i++)
              if (!be_n[d][i]) mem_m[d][idx][8*i +: 8] = wdata[d][8*i +: 8];
          end else begin
            ret_map[key(d, edge_n + lat_of(d))] = mem_m[d][idx];
          end
        end
      end
      exp_wr[d] = rst[d] ? 1'b1 : ((edge_n + 1) < next_ok[d]);
      exp_v[d]  = 1'b0;
      if (!rst[d] && ret_map.exists(key(d, edge_n + 1))) begin
        exp_v[d] = 1'b1;
        exp_d[d] = ret_map[key(d, edge_n + 1)];
        ret_map.delete(key(d, edge_n + 1));
      end
    end
  end

  // ---------------- compare + return log ----------------
  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } ret_t;

  int   cyc = 0;
  ret_t log_a [$];
  ret_t log_b [$];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (started[d]) begin
        check($sformatf("%s.waitrequest", nm(d)), 32'(wreq[d]), 32'(exp_wr[d]));
        check($sformatf("%s.readdatavalid", nm(d)), 32'(rdv[d]), 32'(exp_v[d]));
        check($sformatf("%s.proto_err", nm(d)), 32'(perr[d]), 32'(perr_m[d]));
        if (exp_v[d] === 1'b1)
          check($sformatf("%s.readdata", nm(d)), 32'(rdata[d]), 32'(exp_d[d]));
      end
    end
    if (rdv[0] === 1'b1) log_a.push_back('{cyc, rdata[0]});
    if (rdv[1] === 1'b1) log_b.push_back('{cyc, rdata[1]});
  end

  // ---------------- drivers ----------------
  task automatic idle(input int d);
    cs[d] = 1'b0; rd_n[d] = 1'b1; wr_n[d] = 1'b1;
    addr[d] = '0; wdata[d] = '0; be_n[d] = '1;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic do_cmd(input int d, input bit is_wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] ben,
                        output int acc, output logic wr_after);
    bit done;
    done = 1'b0; acc = -1; wr_after = 1'bx;
    addr[d] = a; wdata[d] = wd; be_n[d] = ben; cs[d] = 1'b1;
    rd_n[d] = is_wr; wr_n[d] = !is_wr;
    for (int t = 0; t < 32 && !done; t++) begin
      if (wreq[d] === 1'b0) begin
        @(posedge clk);
        acc  = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s.accept_timeout: got no accept, expected accept within 32 cycles", nm(d));
    end
    wr_after = wreq[d];
    idle(d);
  endtask

  task automatic wr(input int d, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] ben);
    int acc; logic wa;
    do_cmd(d, 1'b1, a, wd, ben, acc, wa);
  endtask

  task automatic rd_get(input int d, input logic [ADDR_W-1:0] a,
                        output logic [DATA_W-1:0] data, output int lag,
                        output int cnt);
    int acc; logic wa;
    if (d == 0) log_a.delete(); else log_b.delete();
    do_cmd(d, 1'b0, a, '0, '1, acc, wa);
    repeat (lat_of(d) + 2) @(negedge clk);
    #1;
    data = 'x; lag = -1;
    if (d == 0) begin
      cnt = log_a.size();
      if (cnt > 0) begin data = log_a[0].data; lag = log_a[0].cyc - acc; end
    end else begin
      cnt = log_b.size();
      if (cnt > 0) begin data = log_b[0].data; lag = log_b[0].cyc - acc; end
    end
    @(negedge clk);
  endtask

  task automatic illegal(input int d);
    addr[d] = 24'd5; wdata[d] = '0; be_n[d] = '0;
    cs[d] = 1'b1; rd_n[d] = 1'b0; wr_n[d] = 1'b0;
    @(negedge clk);
    idle(d);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [DATA_W-1:0] data;
    int lag, cnt, acc, acc0;
    logic wa;

    for (int d = 0; d < 2; d++) begin
      idle(d);
      rst[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    check("A.reset_waitrequest", 32'(wreq[0]), 32'd1);
    check("A.reset_readdatavalid", 32'(rdv[0]), 32'd0);
    check("A.reset_readdata", 32'(rdata[0]), 32'h0);
    check("A.reset_proto_err", 32'(perr[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("A.waitrequest_after_reset", 32'(wreq[0]), 32'd0);

    // Write then read back; latency and wait-state shape.
    do_cmd(0, 1'b1, 24'h000010, 16'hA5A5, 2'b00, acc, wa);
    check("A.waitrequest_after_accept", 32'(wa), 32'd1);
    rd_get(0, 24'h000010, data, lag, cnt);
    check("A.t1_count", cnt, 1);
    check("A.t1_data", 32'(data), 32'h0000A5A5);
    check("A.t1_latency", lag, 2);

    // Byte-lane merge.
    wr(0, 24'd5, 16'hFFFF, 2'b00);
    wr(0, 24'd5, 16'h1234, 2'b10);
    rd_get(0, 24'd5, data, lag, cnt);
    check("A.lane_data", 32'(data), 32'h0000FF34);

    // Address aliasing modulo 2^MEM_AW.
    wr(0, 24'h000403, 16'h0BEE, 2'b00);
    rd_get(0, 24'h000003, data, lag, cnt);
    check("A.alias_data", 32'(data), 32'h00000BEE);

    // Illegal read+write: flag set and held, no return, memory untouched.
    log_a.delete();
    illegal(0);
    repeat (4) @(negedge clk);
    #1;
    check("A.illegal_proto_err", 32'(perr[0]), 32'd1);
    check("A.illegal_no_return", log_a.size(), 0);
    @(negedge clk);
    rd_get(0, 24'd5, data, lag, cnt);
    check("A.illegal_mem_kept", 32'(data), 32'h0000FF34);
    repeat (5) @(negedge clk);
    check("A.proto_err_held", 32'(perr[0]), 32'd1);

    // Responder B: preload, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      do_cmd(1, 1'b1, 24'(i), 16'(16'h1000 + i), 2'b00, acc, wa);
      if (i == 0) check("B.no_wait_after_accept", 32'(wa), 32'd0);
    end
    log_b.delete();
    acc0 = -1;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1, 1'b0, 24'(i), '0, '1, acc, wa);
      if (i == 0) acc0 = acc;
    end
    repeat (8) @(negedge clk);
    #1;
    check("B.b2b_count", log_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_b.size()) begin
        check($sformatf("B.b2b_cycle%0d", i), log_b[i].cyc - acc0, 3 + i);
        check($sformatf("B.b2b_data%0d", i), 32'(log_b[i].data), 32'h1000 + i);
      end
    end
    @(negedge clk);

    // Reset with two reads in flight.
    illegal(1);
    repeat (2) @(negedge clk);
    #1;
    check("B.illegal_proto_err", 32'(perr[1]), 32'd1);
    @(negedge clk);
    log_b.delete();
    do_cmd(1, 1'b0, 24'd0, '0, '1, acc, wa);
    do_cmd(1, 1'b0, 24'd1, '0, '1, acc, wa);
    rst[1] = 1'b1;
    @(negedge clk);
    #1;
    check("B.reset_waitrequest", 32'(wreq[1]), 32'd1);
    rst[1] = 1'b0;
    @(negedge clk);
    #1;
    check("B.waitrequest_after_reset", 32'(wreq[1]), 32'd0);
    check("B.proto_err_cleared", 32'(perr[1]), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    check("B.inflight_discarded", log_b.size(), 0);
    @(negedge clk);
    rd_get(1, 24'd2, data, lag, cnt);
    check("B.ram_preserved", 32'(data), 32'h00001002);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
